// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational channel picker: fixed priority or round-robin from last_grant+1.
module mem_arb_pick
  import mem_pkg::*;
#(
  parameter int NCH = 2,
  parameter int IW  = ch_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  last_grant,
  input  logic           mode,
  output logic [IW-1:0]  grant,
  output logic           valid
);

  logic [IW-1:0] cand;

  // Walk the channels in search order; the first requester found wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = mode ? IW'((int'(last_grant) + 1 + k) % NCH) : IW'(k);
      if (!valid && req[cand]) begin
        grant = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel arbiter in front of a single-port RAM with fixed wait states.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int WAIT     = 1,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  output logic [NCH-1:0]    ack,
  output logic [DW-1:0]     rdata,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              mem_we,
  output logic              mem_oe,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int            IW       = ch_w(NCH);
  localparam logic [IW-1:0] LAST_RST = IW'(NCH - 1);

  logic [NCH-1:0][AW-1:0] addr_v;
  logic [NCH-1:0][DW-1:0] wdata_v;
  assign addr_v  = addr;
  assign wdata_v = wdata;

  state_t        state;
  logic [3:0]    cnt;
  logic [IW-1:0] cur_ch;
  logic [IW-1:0] last_grant;
  logic          cur_we;
  logic [IW-1:0] pick_ch;
  logic          pick_vld;

  mem_arb_pick #(
    .NCH(NCH),
    .IW (IW)
  ) u_pick (
    .req       (req),
    .last_grant(last_grant),
    .mode      (ARB_MODE == ARB_RR),
    .grant     (pick_ch),
    .valid     (pick_vld)
  );

  // Access sequencer; the RAM strobes are registered so they switch on the
  // grant edge and stay clean for the whole access window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      ack        <= '0;
      mem_we     <= 1'b0;
      mem_oe     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      cnt        <= '0;
      cur_ch     <= '0;
      cur_we     <= 1'b0;
      last_grant <= LAST_RST;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            cur_ch     <= pick_ch;
            last_grant <= pick_ch;
            cur_we     <= we[pick_ch];
            mem_addr   <= addr_v[pick_ch];
            mem_wdata  <= wdata_v[pick_ch];
            mem_we     <= we[pick_ch];
            mem_oe     <= !we[pick_ch];
            cnt        <= 4'(WAIT);
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!cur_we) rdata <= mem_rdata;
            mem_we      <= 1'b0;
            mem_oe      <= 1'b0;
            ack[cur_ch] <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 2: number of requester channels (1..8); ch0 is instruction fetch, ch1 is data.
REQ-002 SHALL have parameter AW, default 16: address width.
REQ-003 SHALL have parameter DW, default 16: data width.
REQ-004 SHALL have parameter WAIT, default 1: memory wait states per access (0..15).
REQ-005 SHALL have parameter ARB_MODE, default 0: 0 is fixed priority, 1 is round-robin.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic samples on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port req, input, NCH bits: per-channel access request.
REQ-009 SHALL have port we, input, NCH bits: per-channel write enable (1 = write).
REQ-010 SHALL have port addr, input, NCH*AW bits: packed per-channel addresses, ch0 in the LSBs.
REQ-011 SHALL have port wdata, input, NCH*DW bits: packed per-channel write data, ch0 in the LSBs.
REQ-012 SHALL have port ack, output, NCH bits: one-cycle completion pulse per channel.
REQ-013 SHALL have port rdata, output, DW bits: read data, shared by all channels.
REQ-014 SHALL have port mem_addr, output, AW bits: RAM address.
REQ-015 SHALL have port mem_wdata, output, DW bits: RAM write data.
REQ-016 SHALL have port mem_we, output, 1 bit: RAM write strobe.
REQ-017 SHALL have port mem_oe, output, 1 bit: RAM output enable.
REQ-018 SHALL have port mem_rdata, input, DW bits: RAM read data.

Function
REQ-019 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-020 IDLE: with any req bit high at an edge, SHALL latch the winning channel index, its addr/we/wdata, and a wait counter = WAIT, then go to ACCESS; with no request, SHALL stay in IDLE.
REQ-021 Fixed mode: SHALL grant the lowest-index requesting channel.
REQ-022 Round-robin mode: SHALL search from (last_grant+1) mod NCH upward with wrap; last_grant updates on each grant.
REQ-023 ACCESS: SHALL drive mem_addr/mem_wdata from the latched values every cycle.
REQ-024 ACCESS: SHALL hold mem_we = latched we and mem_oe = !latched we.
REQ-025 ACCESS: SHALL decrement the counter each cycle; at counter==0 it SHALL go to DONE and, for reads, register mem_rdata into rdata.
REQ-026 DONE: ack[granted] SHALL be 1 for exactly this one cycle; mem_we = mem_oe = 0.
REQ-027 DONE: SHALL go to IDLE unconditionally.
REQ-028 Latency: req sampled at edge E0 -> ack high in the cycle following edge E0+WAIT+1; back-to-back throughput is one access per WAIT+3 cycles.
REQ-029 Requesters SHALL hold req/addr/we/wdata until ack; the block uses only values latched at grant.
REQ-030 Dropping req after grant SHALL NOT abort the access; ack is still issued.
REQ-031 rdata SHALL hold its value until the next read completion; writes leave rdata unchanged.
REQ-032 Outside ACCESS, mem_we and mem_oe SHALL be 0 and mem_addr SHALL hold its last value.
REQ-033 At most one ack bit SHALL be high in any cycle.
REQ-034 With NCH=1, arbitration SHALL degenerate to pass-through, with identical timing.

Reset
REQ-035 On reset==0 at an edge: state = IDLE, ack = 0, mem_we = 0, mem_oe = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, counter = 0, last_grant = NCH-1 (so ch0 is searched first).
REQ-036 Reset during ACCESS SHALL abort the access with no ack; mem_we SHALL be 0 from the cycle after the reset edge.

Structure
REQ-037 Package mem_pkg SHALL hold the state typedef (IDLE, ACCESS, DONE) and constants ARB_FIXED=0 and ARB_RR=1.
REQ-038 The channel pick logic SHALL be sub-module mem_arb_pick, combinational: inputs req, last_grant, mode; outputs grant index and valid.

Verification
REQ-039 Single read: NCH=2, WAIT=1, ch1 read addr 0x0040, RAM returns 0xBEEF -> mem_oe high 2 cycles; ack[1] pulses at E0+3; rdata=0xBEEF.
REQ-040 Write: ch0 write addr 0x0010, data 0x1234, WAIT=0 -> mem_we high for 1 cycle with mem_addr=0x0010 and mem_wdata=0x1234; ack[0] at E0+2; rdata unchanged.
REQ-041 Fixed priority: ch0 and ch1 request in the same cycle and hold until ack -> ch0 served first, ch1 WAIT+3 cycles later.
REQ-042 Round-robin: NCH=3, all channels request continuously -> grant order 0,1,2,0,1,2.
REQ-043 Reset mid-ACCESS: write in flight, reset low for 1 cycle -> mem_we=0 next cycle, no ack, state IDLE; a new request then completes normally.
REQ-044 Early req drop: ch1 drops req one cycle after grant -> ack[1] still pulses at the nominal cycle.
